compact_target_decoder: RTL and testbench

//  Sequential, parametrised decoder for Bitcoin compact "nBits" difficulty words.

---
 rtl/compact_target_decoder.sv | 178 +++++++++++++++++
 tb/tb_compact_target_decoder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/compact_target_decoder.sv
// Expands a Bitcoin compact nBits word into a TARGET_W-bit target with sign/overflow/zero flags.
// Latency: 1 cycle for E<=3, negative or zero mantissa; else 1+ceil((E-3)/BYTES_PER_CYCLE), less on early overflow.
// Backpressure: accepts a word only in IDLE; the result is held in DONE until target_ready_i.
module compact_target_decoder #(
    parameter int TARGET_W        = 256,
    parameter int BYTES_PER_CYCLE = 1
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic [31:0]         bits_i,
    input  logic                bits_valid_i,
    output logic                bits_ready_o,
    output logic [TARGET_W-1:0] target_o,
    output logic                target_valid_o,
    input  logic                target_ready_i,
    output logic                negative_o,
    output logic                overflow_o,
    output logic                zero_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [7:0] LP_BPC = 8'(BYTES_PER_CYCLE);

    state_t              r_state;
    state_t              w_state_nxt;

    logic [TARGET_W-1:0] r_acc;
    logic [7:0]          r_rem;
    logic                r_neg;
    logic                r_ovf;

    // Fields of the incoming word; only meaningful during the IDLE handshake.
    logic [7:0]          w_exp;
    logic                w_sign;
    logic [22:0]         w_mant;
    logic                w_mant_nz;
    logic                w_is_neg;
    logic                w_is_small;
    logic                w_accept;
    logic [1:0]          w_small_bytes;
    logic [TARGET_W-1:0] w_mant_ext;
    logic [TARGET_W-1:0] w_small_val;
    logic [7:0]          w_rem_init;

    // Shift-step helpers; the step shrinks only on the final chunk.
    logic [7:0]          w_step;
    logic [10:0]         w_shamt;
    logic [TARGET_W-1:0] w_ones;
    logic [TARGET_W-1:0] w_top_mask;
    logic                w_top_nz;
    logic                w_acc_zero;
    logic                w_last;

    assign w_exp         = bits_i[31:24];
    assign w_sign        = bits_i[23];
    assign w_mant        = bits_i[22:0];
    assign w_mant_nz     = |w_mant;
    assign w_is_neg      = w_sign & w_mant_nz;
    assign w_is_small    = (w_exp <= 8'd3);
    assign w_accept      = bits_valid_i & (r_state == S_IDLE);
    assign w_small_bytes = 2'd3 - w_exp[1:0];
    assign w_mant_ext    = {{(TARGET_W-23){1'b0}}, w_mant};
    assign w_small_val   = w_mant_ext >> {w_small_bytes, 3'b000};
    assign w_rem_init    = w_exp - 8'd3;

    assign w_step        = (r_rem < LP_BPC) ? r_rem : LP_BPC;
    assign w_shamt       = {w_step, 3'b000};
    assign w_ones        = {TARGET_W{1'b1}};
    // Bytes that would fall off the top if this step were applied.
    assign w_top_mask    = ~(w_ones >> w_shamt);
    assign w_top_nz      = |(r_acc & w_top_mask);
    assign w_acc_zero    = ~|r_acc;
    assign w_last        = (r_rem <= LP_BPC);

    // State register with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decision.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    // Negative, small-exponent and zero-mantissa words need no shifting.
                    if (w_is_neg || w_is_small || !w_mant_nz) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                if (w_acc_zero || w_top_nz || w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (target_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Accumulator, byte counter and sticky flags.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_acc <= '0;
            r_rem <= '0;
            r_neg <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_neg <= w_is_neg;
                        r_ovf <= 1'b0;
                        r_rem <= '0;
                        if (w_is_neg) begin
                            r_acc <= '0;
                        end else if (w_is_small) begin
                            r_acc <= w_small_val;
                        end else begin
                            r_acc <= w_mant_ext;
                            r_rem <= w_rem_init;
                        end
                    end
                end
                S_SHIFT: begin
                    if (w_acc_zero) begin
                        r_rem <= '0;
                    end else if (w_top_nz) begin
                        // Nonzero bytes would be lost: report overflow with a zero target.
                        r_ovf <= 1'b1;
                        r_acc <= '0;
                        r_rem <= '0;
                    end else begin
                        r_acc <= r_acc << w_shamt;
                        r_rem <= r_rem - w_step;
                    end
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

    // Outputs are only presented in DONE so they read as zero elsewhere.
    always_comb begin
        bits_ready_o   = (r_state == S_IDLE);
        target_valid_o = 1'b0;
        target_o       = '0;
        negative_o     = 1'b0;
        overflow_o     = 1'b0;
        zero_o         = 1'b0;
        if (r_state == S_DONE) begin
            target_valid_o = 1'b1;
            target_o       = r_acc;
            negative_o     = r_neg;
            overflow_o     = r_ovf;
            zero_o         = w_acc_zero & ~r_neg & ~r_ovf;
        end
    end

endmodule

// File: tb/tb_compact_target_decoder.sv
// Bench for compact_target_decoder: two instances, BYTES_PER_CYCLE=1 and 4.
// Directed table, hand sequences for hold/back-to-back/reset, then random words vs a model.
// Consumer ready is driven by the bench with configurable hold-off.
module tb_compact_target_decoder;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  bits  [2];
    logic         vld   [2];
    logic         rdy   [2];
    logic [255:0] tgt   [2];
    logic         tv    [2];
    logic         trdy  [2];
    logic         neg   [2];
    logic         ovf   [2];
    logic         zro   [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    compact_target_decoder #(.TARGET_W(256), .BYTES_PER_CYCLE(1)) u_dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .bits_i(bits[0]), .bits_valid_i(vld[0]),
        .bits_ready_o(rdy[0]), .target_o(tgt[0]), .target_valid_o(tv[0]),
        .target_ready_i(trdy[0]), .negative_o(neg[0]), .overflow_o(ovf[0]), .zero_o(zro[0])
    );

    compact_target_decoder #(.TARGET_W(256), .BYTES_PER_CYCLE(4)) u_dut4 (
        .wb_clk_i(clk), .wb_rst_i(rst), .bits_i(bits[1]), .bits_valid_i(vld[1]),
        .bits_ready_o(rdy[1]), .target_o(tgt[1]), .target_valid_o(tv[1]),
        .target_ready_i(trdy[1]), .negative_o(neg[1]), .overflow_o(ovf[1]), .zero_o(zro[1])
    );

    typedef struct {
        logic [31:0]  w;
        int           k;     // 0: one byte per cycle, 1: four bytes per cycle
        logic [255:0] t;
        logic [2:0]   f;     // {negative, overflow, zero}
        int           lat;
    } vec_t;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: target = M * 256^(E-3) evaluated in a wide integer, then range-checked.
    task automatic model(input logic [31:0] w, input int bpc,
                         output logic [255:0] t, output logic [2:0] f, output int lat);
        logic [7:0]    e;
        logic [22:0]   m;
        logic          n, o, z;
        logic [2079:0] full;
        int            nb, rem, free;
        e = w[31:24];
        m = w[22:0];
        n = w[23] && (m != 0);
        o = 1'b0;
        lat = 1;
        if (n) begin
            t = '0;
        end else if (e <= 3) begin
            t = 256'(m) / (256'(1) << (8 * (3 - int'(e))));
        end else begin
            full = 2080'(m) << (8 * (int'(e) - 3));
            o = |(full >> 256);
            t = o ? 256'(0) : full[255:0];
            if (m != 0) begin
                nb = 0;
                for (int b = 0; b < 3; b++) if (((m >> (8 * b)) & 23'hff) != 0) nb = b + 1;
                rem  = int'(e) - 3;
                free = 32 - nb;
                if (!o) lat = 1 + (rem + bpc - 1) / bpc;
                else    lat = 2 + free / bpc;
            end
        end
        z = (t == 0) && !n && !o;
        f = {n, o, z};
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_word(input int k, input logic [31:0] w, input logic [255:0] et,
                            input logic [2:0] ef, input int el, input int hold, input string tag);
        int n;
        int lat;
        chk({tag, "_ready_on_entry"}, 256'(rdy[k]), 256'(1));
        bits[k] = w;
        vld[k]  = 1'b1;
        n = 0;
        while (!rdy[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        vld[k]  = 1'b0;
        bits[k] = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!tv[k] && lat < 400);
        chk({tag, "_latency"}, 256'(lat), 256'(el));
        chk({tag, "_target"}, tgt[k], et);
        chk({tag, "_flags"}, 256'({neg[k], ovf[k], zro[k]}), 256'(ef));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 256'(tv[k]), 256'(1));
            chk({tag, "_hold_ready"}, 256'(rdy[k]), 256'(0));
            chk({tag, "_hold_target"}, tgt[k], et);
            chk({tag, "_hold_flags"}, 256'({neg[k], ovf[k], zro[k]}), 256'(ef));
        end
        trdy[k] = 1'b1;
        @(negedge clk);
        trdy[k] = 1'b0;
        chk({tag, "_release_valid"}, 256'(tv[k]), 256'(0));
        chk({tag, "_release_ready"}, 256'(rdy[k]), 256'(1));
    endtask

    vec_t tbl[13];

    initial begin
        logic [255:0] et;
        logic [2:0]   ef;
        int           el;
        logic [31:0]  w;
        bit           seen;

        for (int k = 0; k < 2; k++) begin
            bits[k] = '0; vld[k] = 1'b0; trdy[k] = 1'b0;
        end

        tbl[0]  = '{32'h1d00ffff, 0, 256'h00ffff << 208, 3'b000, 27};
        tbl[1]  = '{32'h03123456, 0, 256'h123456,        3'b000, 1};
        tbl[2]  = '{32'h01123456, 0, 256'h12,            3'b000, 1};
        tbl[3]  = '{32'h00123456, 0, 256'h0,             3'b001, 1};
        tbl[4]  = '{32'h04923456, 0, 256'h0,             3'b100, 1};
        tbl[5]  = '{32'h04800000, 0, 256'h0,             3'b001, 1};
        tbl[6]  = '{32'h20010000, 0, 256'h1 << 248,      3'b000, 30};
        tbl[7]  = '{32'h21010000, 0, 256'h0,             3'b010, 31};
        tbl[8]  = '{32'h20010000, 1, 256'h1 << 248,      3'b000, 9};
        tbl[9]  = '{32'h21010000, 1, 256'h0,             3'b010, 9};
        tbl[10] = '{32'hff7fffff, 0, 256'h0,             3'b010, 31};
        tbl[11] = '{32'h02008000, 0, 256'h80,            3'b000, 1};
        tbl[12] = '{32'h05000000, 1, 256'h0,             3'b001, 1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state of both instances.
        for (int k = 0; k < 2; k++) begin
            chk("reset_ready",  256'(rdy[k]), 256'(1));
            chk("reset_valid",  256'(tv[k]),  256'(0));
            chk("reset_target", tgt[k],       256'(0));
            chk("reset_flags",  256'({neg[k], ovf[k], zro[k]}), 256'(0));
        end

        // Directed table.
        for (int i = 0; i < 13; i++) begin
            run_word(tbl[i].k, tbl[i].w, tbl[i].t, tbl[i].f, tbl[i].lat, 0, $sformatf("vec%0d", i));
        end

        // Consumer stalls 5 cycles, then a word follows straight after release.
        run_word(0, 32'h1d00ffff, 256'h00ffff << 208, 3'b000, 27, 5, "hold5");
        run_word(0, 32'h03123456, 256'h123456, 3'b000, 1, 0, "b2b");

        // Reset in the 10th cycle of a long decode.
        bits[0] = 32'h1d00ffff;
        vld[0]  = 1'b1;
        @(posedge clk);
        #1;
        vld[0] = 1'b0;
        repeat (9) @(negedge clk);
        chk("midop_busy_ready", 256'(rdy[0]), 256'(0));
        chk("midop_busy_valid", 256'(tv[0]),  256'(0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready",  256'(rdy[0]), 256'(1));
        chk("midrst_valid",  256'(tv[0]),  256'(0));
        chk("midrst_target", tgt[0],       256'(0));
        chk("midrst_flags",  256'({neg[0], ovf[0], zro[0]}), 256'(0));
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (tv[0]) seen = 1'b1;
        end
        chk("midrst_no_late_valid", 256'(seen), 256'(0));
        run_word(0, 32'h0400ff00, 256'hff0000, 3'b000, 2, 1, "after_rst");

        // Random words against the model on both instances.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 60; i++) begin
                w[31:24] = ($urandom_range(0, 9) < 7) ? 8'($urandom_range(0, 40))
                                                      : 8'($urandom_range(0, 255));
                w[23]    = ($urandom_range(0, 3) == 0);
                w[22:0]  = ($urandom_range(0, 5) == 0) ? 23'h0
                                                       : 23'($urandom) >> $urandom_range(0, 22);
                model(w, (k == 0) ? 1 : 4, et, ef, el);
                run_word(k, w, et, ef, el, $urandom_range(0, 2), $sformatf("rnd%0d_%0d", k, i));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no end expected end");
        $fatal(1, "watchdog");
    end

endmodule
